fifo_stream_reader: RTL and testbench

- Reader-side adapter that drains the team's synchronous FIFO and presents its contents as a valid/ready stream.
- Issues FIFO reads, tracks the 1-cycle registered read latency and catches returned words in a 2-entry skid buffer.
- Sustains 1 word/cycle under continuous downstream ready.
- Sits between the FIFO read port and any stream consumer (e.g. serializer, DMA sink).

---
 rtl/fifo_stream_pkg.sv | 13 +
 rtl/stream_skid_buf.sv | 95 +++++++++
 rtl/fifo_stream_reader.sv | 59 +++++
 tb/tb_fifo_stream_reader.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO-to-stream reader: skid buffer occupancy states and depth.
package fifo_stream_pkg;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order skid buffer; head entry drives the stream.
// Latency: push visible on o_valid/o_data the cycle after capture.
// Backpressure: holds head until i_pop; flush empties it and drops a same-cycle push.
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  logic [DataWidth-1:0] i_push_data,
    input  logic                 i_pop,
    input  logic                 i_flush,
    output logic                 o_valid,
    output logic [DataWidth-1:0] o_data,
    output logic [OCC_W-1:0]     o_occ
);

    buf_state_e           state, state_next;
    logic [DataWidth-1:0] entry0, entry1;
    logic                 wr_head, wr_tail, shift;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) state <= BUF_EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr_head    = 1'b0;
        wr_tail    = 1'b0;
        shift      = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (i_push) begin
                    state_next = BUF_ONE;
                    wr_head    = 1'b1;
                end
            end
            BUF_ONE: begin
                if (i_push && !i_pop) begin
                    state_next = BUF_TWO;
                    wr_tail    = 1'b1;
                end else if (i_push && i_pop) begin
                    wr_head = 1'b1;
                end else if (i_pop) begin
                    state_next = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (i_pop) begin
                    shift = 1'b1;
                    if (i_push) wr_tail = 1'b1;
                    else        state_next = BUF_ONE;
                end
            end
            default: state_next = BUF_EMPTY;
        endcase
        if (i_flush) begin
            state_next = BUF_EMPTY;
            wr_head    = 1'b0;
            wr_tail    = 1'b0;
            shift      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            if (wr_head)    entry0 <= i_push_data;
            else if (shift) entry0 <= entry1;
            if (wr_tail)    entry1 <= i_push_data;
        end
    end

    always_comb begin
        o_occ = '0;
        case (state)
            BUF_ONE: o_occ = OCC_W'(1);
            BUF_TWO: o_occ = OCC_W'(2);
            default: o_occ = '0;
        endcase
    end

    assign o_valid = (state != BUF_EMPTY);
    assign o_data  = entry0;

    // The read-issue rule never lets a word land in a full buffer that is not draining.
    a_no_overflow: assert property (@(posedge clk) disable iff (i_rst)
        !(state == BUF_TWO && i_push && !i_pop && !i_flush));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream at up to 1 word/cycle.
// Latency: read strobe in cycle N, o_valid in cycle N+2 (one FIFO cycle, one capture cycle).
// Backpressure: reads are issued only when the skid buffer can absorb them; i_ready feeds the issue path.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  i_rst,
    output logic                  o_fifo_read,
    input  logic [DataWidth-1:0]  i_fifo_read_data,
    input  logic                  i_fifo_empty,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [DataWidth-1:0]  o_data,
    input  logic                  i_ready,
    output logic [CountWidth-1:0] o_beat_count
);

    logic             inflight;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   pending;
    logic [OCC_W:0]   room_limit;

    assign pop = o_valid && i_ready;

    // Entries held plus the word in flight, less the one leaving now, must stay below depth.
    assign pending     = {1'b0, occ} + (OCC_W + 1)'(inflight);
    assign room_limit  = (OCC_W + 1)'(SKID_DEPTH) + (OCC_W + 1)'(pop);
    assign o_fifo_read = !i_rst && !i_flush && !i_fifo_empty && (pending < room_limit);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) inflight <= 1'b0;
        else       inflight <= o_fifo_read;
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)                 o_beat_count <= '0;
        else if (pop && !i_flush)  o_beat_count <= o_beat_count + CountWidth'(1);
    end

    stream_skid_buf #(
        .DataWidth(DataWidth)
    ) u_skid (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_push     (inflight),
        .i_push_data(i_fifo_read_data),
        .i_pop      (pop),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_occ      (occ)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO and reader model, randomized data and handshakes.
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          o_fifo_read;
    logic [DW-1:0] i_fifo_read_data;
    logic          i_fifo_empty;
    logic          i_flush;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic [CW-1:0] o_beat_count;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DataWidth(DW), .CountWidth(CW)) dut (
        .clk             (clk),
        .i_rst           (i_rst),
        .o_fifo_read     (o_fifo_read),
        .i_fifo_read_data(i_fifo_read_data),
        .i_fifo_empty    (i_fifo_empty),
        .i_flush         (i_flush),
        .o_valid         (o_valid),
        .o_data          (o_data),
        .i_ready         (i_ready),
        .o_beat_count    (o_beat_count)
    );

    logic [DW-1:0] fq[$];     // words still inside the FIFO
    logic [DW-1:0] mbuf[$];   // words the reader holds, oldest first
    logic          m_inf;
    logic [DW-1:0] m_word;
    logic [CW-1:0] cnt;
    logic          c_rd, c_pop, c_flush;
    int            checks, errors;
    int            cyc, nrd, rd_step, vld_step;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic fl, input int nwr);
        logic ev, epop, erd;
        int   held;
        @(negedge clk);
        if (c_flush) begin
            mbuf.delete();
            m_inf = 1'b0;
        end else begin
            if (c_pop) begin
                void'(mbuf.pop_front());
                cnt = cnt + 1'b1;
            end
            if (m_inf) mbuf.push_back(m_word);
            m_inf = 1'b0;
        end
        if (c_rd) begin
            m_word           = fq.pop_front();
            m_inf            = 1'b1;
            i_fifo_read_data = m_word;
        end else begin
            i_fifo_read_data = $urandom();
        end
        for (int k = 0; k < nwr; k++) fq.push_back($urandom());
        i_ready      = rdy;
        i_flush      = fl;
        i_fifo_empty = (fq.size() == 0);
        #1;
        ev   = (mbuf.size() != 0);
        epop = ev && rdy;
        held = mbuf.size() + int'(m_inf) - int'(epop);
        erd  = !fl && (fq.size() != 0) && (held < 2);
        chk("valid", {31'b0, o_valid}, {31'b0, ev});
        if (ev) chk("data", o_data, mbuf[0]);
        chk("read", {31'b0, o_fifo_read}, {31'b0, erd});
        chk("beats", {28'b0, o_beat_count}, {28'b0, cnt});
        c_rd    = erd;
        c_pop   = epop;
        c_flush = fl;
        if (o_fifo_read) nrd++;
        if (rd_step < 0 && o_fifo_read) rd_step = cyc;
        if (vld_step < 0 && o_valid)    vld_step = cyc;
        cyc++;
    endtask

    task automatic model_reset();
        mbuf.delete();
        m_inf   = 1'b0;
        cnt     = '0;
        c_rd    = 1'b0;
        c_pop   = 1'b0;
        c_flush = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; nrd = 0;
        rd_step = -1; vld_step = -1;
        model_reset();
        i_rst = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
        i_fifo_read_data = '0;
        for (int k = 0; k < 3; k++) fq.push_back($urandom());
        i_fifo_empty = 1'b0;

        // Reset state with a non-empty FIFO
        #2;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_beats", {28'b0, o_beat_count}, 32'd0);
        chk("rst_read", {31'b0, o_fifo_read}, 32'd0);
        repeat (2) @(posedge clk);
        #2 i_rst = 1'b0;

        // Three words streamed with i_ready high
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 0);
        chk("first_latency", vld_step - rd_step, 32'd2);
        chk("three_beats", {28'b0, o_beat_count}, 32'd3);

        // Stall: only two reads while the consumer holds off
        nrd = 0;
        step(1'b0, 1'b0, 5);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 0);
        chk("stall_reads", nrd, 32'd2);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 0);

        // Alternating ready over eight words
        step(1'b1, 1'b0, 8);
        for (int k = 0; k < 20; k++) step(k[0], 1'b0, 0);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 0);

        // Empty FIFO for a while, then a single word
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 0);
        rd_step = -1; vld_step = -1;
        step(1'b1, 1'b0, 1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0);
        chk("single_latency", vld_step - rd_step, 32'd2);

        // Flush with one word held and one in flight
        step(1'b0, 1'b0, 4);
        step(1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 0);

        // Randomized traffic, flushes and counter wrap
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);

        // Asynchronous reset between edges during a burst
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 2);
        #1 i_rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, o_valid}, 32'd0);
        chk("arst_read", {31'b0, o_fifo_read}, 32'd0);
        chk("arst_beats", {28'b0, o_beat_count}, 32'd0);
        model_reset();
        @(posedge clk);
        #2 i_rst = 1'b0;
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
